axis_spi_arbiter: RTL and testbench
===================================

Name: axis_spi_arbiter

Overview:
- Shares one axis_spi_master between NUM_REQ independent AXI-Stream requesters.
- Arbitrates round-robin at frame granularity (a frame ends on tlast) and drives the master's addr_i with the winner's slave address.
- Forwards TX bytes to the master and routes each returned MISO byte back to the granted requester.
- Holds the grant until all response bytes of the frame have returned, then inserts a programmable idle gap before re-arbitrating.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, byte width, equal to master DATA_WIDTH
SLAVE_NUM, 4, number of SPI chip selects on the master
ADDR_W, (SLAVE_NUM>1 ? $clog2(SLAVE_NUM) : 1), width of addr_o
REQ_ADDR, {4{2'd0}} flattened, NUM_REQ x ADDR_W slave address per requester, requester i at bits [i*ADDR_W +: ADDR_W]
MAX_BURST, 16, max beats per grant before forced release
GAP_CYCLES, 4, clk_i cycles of idle between grants (0 = none)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active high
req_tdata_i  in  NUM_REQ*DATA_WIDTH  requester TX bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_tvalid_i  in  NUM_REQ  requester TX valid
req_tlast_i  in  NUM_REQ  requester end of frame
req_tready_o  out  NUM_REQ  requester TX ready
rsp_tdata_o  out  DATA_WIDTH  response byte, shared by all requesters
rsp_tvalid_o  out  NUM_REQ  response valid, one-hot to granted requester
rsp_tready_i  in  NUM_REQ  response ready
m_tdata_o  out  DATA_WIDTH  to master s_axis tdata
m_tvalid_o  out  1  to master s_axis tvalid
m_tready_i  in  1  from master s_axis tready
s_tdata_i  in  DATA_WIDTH  from master m_axis tdata
s_tvalid_i  in  1  from master m_axis tvalid
s_tready_o  out  1  to master m_axis tready
addr_o  out  ADDR_W  to master addr_i
grant_o  out  NUM_REQ  one-hot current grant, 0 when none
busy_o  out  1  high in any state except IDLE
trunc_o  out  1  1-cycle pulse when a grant is force-released by MAX_BURST

Behaviour:
- Reset (rst_i high at clk_i edge): state=IDLE; grant_o=0; addr_o=0; busy_o=0; trunc_o=0; beat and outstanding counters=0; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE -> XFER: on a cycle where any req_tvalid_i is high, the winner is chosen. Search starts at pointer+1 and wraps modulo NUM_REQ. grant_o, addr_o=REQ_ADDR[winner] and pointer=winner are registered, so the grant is visible the next cycle. No beat passes in the arbitration cycle.
  - XFER: combinational forwarding of the granted requester g only. m_tdata_o/m_tvalid_o follow requester g; req_tready_o[g]=m_tready_i. All other req_tready_o bits are 0.
    - TX handshake = m_tvalid_o & m_tready_i.
    - Each TX handshake increments beat_cnt and outstanding.
    - Handshake with tlast -> DRAIN.
    - Handshake that brings beat_cnt to MAX_BURST without tlast -> DRAIN, and trunc_o pulses the following cycle.
  - DRAIN: req_tready_o=0. Exits when outstanding==0 -> GAP, or -> IDLE if GAP_CYCLES==0.
  - GAP: count GAP_CYCLES cycles, then IDLE. grant_o clears on GAP entry. addr_o holds its last value.
- Response path, active in XFER and DRAIN:
  - rsp_tdata_o=s_tdata_i; rsp_tvalid_o[g]=s_tvalid_i; s_tready_o=rsp_tready_i[g].
  - Each response handshake decrements outstanding.
  - TX and RX handshakes in the same cycle leave outstanding unchanged.
- In IDLE and GAP: s_tready_o=1 and rsp_tvalid_o=0; stray master responses are consumed and dropped.
- Outstanding counter is $clog2(MAX_BURST+1) bits. It never underflows: a decrement when it is already 0 cannot occur with the grant held, because stray responses are only accepted in IDLE or GAP.
- addr_o is stable from the grant cycle through the end of DRAIN. It never changes while outstanding!=0.
- A request that drops tvalid mid-frame leaves the grant held; the arbiter waits indefinitely for tlast or MAX_BURST.
- Mid-operation rst_i: returns to reset values on the next edge. Partial frames are abandoned and no response is routed.
- busy_o = (state != IDLE).

Test Plan:
- Single requester 1 sends 3-byte frame 0xA1,0xA2,0xA3(tlast), REQ_ADDR[1]=2, looped MISO -> addr_o=2 from grant cycle; grant_o=4'b0010; rsp_tvalid_o[1] returns 0xA1,0xA2,0xA3; then GAP of 4 cycles; then busy_o=0.
- All 4 requesters hold 1-byte frames continuously -> grant order 0,1,2,3,0; each grant separated by >=GAP_CYCLES+1 idle cycles; no response leaks to a non-granted requester.
- Requester 2 sends 20 bytes without tlast, MAX_BURST=16 -> exactly 16 beats accepted; trunc_o pulses once; grant released after 16 responses; next arbitration again offers requester 2 only after 3 and 0 are serviced.
- rsp_tready_i[0] held low for 10 cycles during a frame -> s_tready_o=0 for those cycles; grant held in DRAIN until all responses are accepted; outstanding returns to 0.
- Simultaneous TX and RX handshake every cycle over a 5-byte frame -> outstanding stays at 1; DRAIN lasts until the final response arrives.
- rst_i asserted mid-XFER after 2 of 4 beats -> next cycle grant_o=0, busy_o=0, all req_tready_o=0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/axis_spi_arbiter.sv
// Purpose: shares one SPI master between NUM_REQ AXI-Stream requesters, round-robin per frame.
// Latency: grant registered one cycle after arbitration; TX and RX paths are combinational passthrough.
// Backpressure: TX ready and RX ready pass straight through to/from the granted requester only.
module axis_spi_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SLAVE_NUM  = 4,
    parameter int ADDR_W     = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
    parameter logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR = '0,
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [NUM_REQ-1:0]            req_tvalid_i,
    input  logic [NUM_REQ-1:0]            req_tlast_i,
    output logic [NUM_REQ-1:0]            req_tready_o,
    output logic [DATA_WIDTH-1:0]         rsp_tdata_o,
    output logic [NUM_REQ-1:0]            rsp_tvalid_o,
    input  logic [NUM_REQ-1:0]            rsp_tready_i,
    output logic [DATA_WIDTH-1:0]         m_tdata_o,
    output logic                          m_tvalid_o,
    input  logic                          m_tready_i,
    input  logic [DATA_WIDTH-1:0]         s_tdata_i,
    input  logic                          s_tvalid_i,
    output logic                          s_tready_o,
    output logic [ADDR_W-1:0]             addr_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          trunc_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PW-1:0]        r_gidx;
    logic [PW-1:0]        r_ptr;
    logic [ADDR_W-1:0]    r_addr;
    logic [CW-1:0]        r_beat;
    logic [CW-1:0]        r_outst;
    logic [31:0]          r_gap;
    logic                 r_trunc;

    logic [PW-1:0]        w_win;
    logic [PW-1:0]        w_cand;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic                 w_found;
    logic                 w_route;
    logic                 w_tx_hs;
    logic                 w_rx_hs;
    logic                 w_last;
    logic                 w_burst_end;

    // Response routing is live while a grant is held (transfer and drain).
    assign w_route     = (r_state == S_XFER) || (r_state == S_DRAIN);
    assign w_tx_hs     = m_tvalid_o & m_tready_i;
    assign w_rx_hs     = w_route & s_tvalid_i & s_tready_o;
    assign w_last      = req_tlast_i[r_gidx];
    assign w_burst_end = (r_beat == CW'(MAX_BURST - 1));

    assign rsp_tdata_o = s_tdata_i;
    assign grant_o     = r_grant;
    assign addr_o      = r_addr;
    assign busy_o      = (r_state != S_IDLE);
    assign trunc_o     = r_trunc;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        w_win    = r_ptr;
        w_cand   = r_ptr;
        w_found  = 1'b0;
        w_win_oh = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_tvalid_i[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
        w_win_oh[w_win] = 1'b1;
    end

    // TX and RX forwarding for the granted requester; strays are sunk while no grant is held.
    always_comb begin
        req_tready_o = '0;
        m_tvalid_o   = 1'b0;
        m_tdata_o    = req_tdata_i[r_gidx*DATA_WIDTH +: DATA_WIDTH];
        rsp_tvalid_o = '0;
        s_tready_o   = 1'b1;
        if (r_state == S_XFER) begin
            m_tvalid_o           = req_tvalid_i[r_gidx];
            req_tready_o[r_gidx] = m_tready_i;
        end
        if (w_route) begin
            rsp_tvalid_o[r_gidx] = s_tvalid_i;
            s_tready_o           = rsp_tready_i[r_gidx];
        end
    end

    // Next-state logic: frame end or burst limit closes TX; drain waits for every response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_tx_hs && (w_last || w_burst_end)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_outst == '0) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (r_gap >= 32'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant, address, pointer, beat/outstanding counters, gap timer and truncation pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_addr  <= '0;
            r_beat  <= '0;
            r_outst <= '0;
            r_gap   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= w_tx_hs && w_burst_end && !w_last;

            if ((r_state == S_IDLE) && w_found) begin
                r_grant <= w_win_oh;
                r_gidx  <= w_win;
                r_ptr   <= w_win;
                r_addr  <= REQ_ADDR[w_win*ADDR_W +: ADDR_W];
                r_beat  <= '0;
            end else if (w_tx_hs) begin
                r_beat  <= r_beat + 1'b1;
            end

            // Grant drops as soon as drain finishes; address is left as-is.
            if ((r_state == S_DRAIN) && (w_state_nxt != S_DRAIN)) r_grant <= '0;

            case ({w_tx_hs, w_rx_hs})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   if (r_outst != '0) r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase

            if (r_state == S_GAP) r_gap <= r_gap + 32'd1;
            else                  r_gap <= '0;
        end
    end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Purpose: directed self-checking bench for axis_spi_arbiter with loopback master model.
// Latency: stimulus driven 1-3 time units after posedge, outputs sampled at +3 or negedge.
// Backpressure: master always ready unless a test drops it; response ready controlled per test.
module tb_axis_spi_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR*DW-1:0]  req_tdata_i;
    logic [NR-1:0]     req_tvalid_i;
    logic [NR-1:0]     req_tlast_i;
    logic [NR-1:0]     req_tready_o;
    logic [DW-1:0]     rsp_tdata_o;
    logic [NR-1:0]     rsp_tvalid_o;
    logic [NR-1:0]     rsp_tready_i;
    logic [DW-1:0]     m_tdata_o;
    logic              m_tvalid_o;
    logic              m_tready_i;
    logic [DW-1:0]     s_tdata_i;
    logic              s_tvalid_i;
    logic              s_tready_o;
    logic [AW-1:0]     addr_o;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              trunc_o;

    always #5 clk_i = ~clk_i;

    axis_spi_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .SLAVE_NUM(4), .ADDR_W(2),
        .REQ_ADDR(8'b11_01_10_00), .MAX_BURST(16), .GAP_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_tdata_i(req_tdata_i), .req_tvalid_i(req_tvalid_i),
        .req_tlast_i(req_tlast_i), .req_tready_o(req_tready_o),
        .rsp_tdata_o(rsp_tdata_o), .rsp_tvalid_o(rsp_tvalid_o),
        .rsp_tready_i(rsp_tready_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .addr_o(addr_o), .grant_o(grant_o), .busy_o(busy_o), .trunc_o(trunc_o)
    );

    // Requester sources, response logs, loopback master queue, grant history.
    logic [8:0] src_mem [NR][64];
    int         src_wr  [NR];
    int         src_rd  [NR];
    logic [7:0] rx_mem  [NR][64];
    int         rx_cnt  [NR];
    logic [7:0] mq [256];
    int         mq_h, mq_t;
    int         glog [32];
    int         glog_n, idle_run, min_idle, leak_cnt, trunc_cnt;
    logic       had_grant;
    logic [NR-1:0] prev_grant, m_hs;
    logic       m_tx, m_rx;
    logic [7:0] m_txd;

    int checks = 0;
    int errors = 0;

    function automatic int oh2i(input logic [NR-1:0] oh);
        int r = -1;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Environment model: requesters pop on handshake, master echoes each TX byte back one cycle later.
    initial begin
        req_tvalid_i = '0; req_tdata_i = '0; req_tlast_i = '0;
        s_tvalid_i = 1'b0; s_tdata_i = '0;
        mq_h = 0; mq_t = 0; glog_n = 0; idle_run = 0; min_idle = 999;
        leak_cnt = 0; trunc_cnt = 0; had_grant = 1'b0; prev_grant = '0;
        for (int i = 0; i < NR; i++) begin src_wr[i] = 0; src_rd[i] = 0; rx_cnt[i] = 0; end
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < NR; i++) m_hs[i] = req_tvalid_i[i] & req_tready_o[i];
            m_tx  = m_tvalid_o & m_tready_i;
            m_txd = m_tdata_o;
            m_rx  = s_tvalid_i & s_tready_o;
            for (int i = 0; i < NR; i++) begin
                if (rsp_tvalid_o[i] && rsp_tready_i[i]) begin
                    if (rx_cnt[i] < 64) rx_mem[i][rx_cnt[i]] = rsp_tdata_o;
                    rx_cnt[i]++;
                end
            end
            if ((rsp_tvalid_o & ~grant_o) != '0) leak_cnt++;
            if (trunc_o) trunc_cnt++;
            if (grant_o != '0 && prev_grant == '0) begin
                if (had_grant && idle_run < min_idle) min_idle = idle_run;
                had_grant = 1'b1;
                if (glog_n < 32) glog[glog_n] = oh2i(grant_o);
                glog_n++;
            end
            if (grant_o == '0) idle_run++; else idle_run = 0;
            prev_grant = grant_o;

            @(posedge clk_i);
            #1;
            for (int i = 0; i < NR; i++) if (m_hs[i]) src_rd[i]++;
            if (m_rx) mq_h++;
            if (m_tx && mq_t < 256) begin mq[mq_t] = m_txd; mq_t++; end
            for (int i = 0; i < NR; i++) begin
                if (src_rd[i] < src_wr[i]) begin
                    req_tvalid_i[i]        = 1'b1;
                    req_tdata_i[i*DW +: DW] = src_mem[i][src_rd[i]][7:0];
                    req_tlast_i[i]         = src_mem[i][src_rd[i]][8];
                end else begin
                    req_tvalid_i[i] = 1'b0;
                    req_tlast_i[i]  = 1'b0;
                end
            end
            s_tvalid_i = (mq_h != mq_t);
            s_tdata_i  = (mq_h < 256) ? mq[mq_h] : 8'h00;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #3;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d0, input int len, input logic last_at_end);
        for (int k = 0; k < len; k++) begin
            src_mem[r][src_wr[r]] = {last_at_end && (k == len - 1), 8'(d0 + 8'(k))};
            src_wr[r]++;
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        logic done;
        int   n;
        done = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            done = !busy_o && (mq_h == mq_t);
            for (int i = 0; i < NR; i++) if (src_rd[i] != src_wr[i]) done = 1'b0;
            if (!done) tick();
            n++;
        end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_grant(input string nm, input logic [NR-1:0] exp, input int budget);
        int n = 0;
        while (grant_o != exp && n < budget) begin tick(); n++; end
        chk(nm, {28'd0, grant_o}, {28'd0, exp});
    endtask

    task automatic check_rx(input string nm, input int r, input int base, input logic [7:0] d0, input int len);
        int bad = 0;
        for (int k = 0; k < len; k++)
            if (rx_mem[r][base + k] !== 8'(d0 + 8'(k))) bad++;
        chk({nm, "_cnt"}, rx_cnt[r] - base, len);
        chk({nm, "_data_bad"}, bad, 0);
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    typedef struct {
        int         req;
        int         len;
        logic [7:0] d0;
        logic [1:0] addr;
        logic [3:0] grant;
        int         gcyc;
    } vec_t;

    vec_t vt [4];

    initial begin
        int   rx0, sr0, n, gcyc, gapc, amis, omax, viol, gseen;
        // Frames served one at a time; grant held for len+2 cycles with an always-ready loopback master.
        vt[0] = '{1, 3, 8'hA1, 2'd2, 4'b0010, 5};
        vt[1] = '{0, 1, 8'h10, 2'd0, 4'b0001, 3};
        vt[2] = '{2, 5, 8'h50, 2'd1, 4'b0100, 7};
        vt[3] = '{3, 2, 8'hC0, 2'd3, 4'b1000, 4};

        rst_i = 1'b1;
        m_tready_i = 1'b1;
        rsp_tready_i = '1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_grant",  {28'd0, grant_o}, 32'd0);
        chk("rst_addr",   {30'd0, addr_o}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o}, 32'd0);
        chk("rst_trunc",  {31'd0, trunc_o}, 32'd0);
        chk("rst_treq",   {28'd0, req_tready_o}, 32'd0);
        chk("rst_sready", {31'd0, s_tready_o}, 32'd1);
        chk("rst_rspv",   {28'd0, rsp_tvalid_o}, 32'd0);
        chk("rst_mvalid", {31'd0, m_tvalid_o}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            rx0 = rx_cnt[vt[v].req];
            push(vt[v].req, vt[v].d0, vt[v].len, 1'b1);
            n = 0;
            while (grant_o == '0 && n < 20) begin tick(); n++; end
            chk($sformatf("v%0d_grant", v), {28'd0, grant_o}, {28'd0, vt[v].grant});
            chk($sformatf("v%0d_addr", v), {30'd0, addr_o}, {30'd0, vt[v].addr});
            gcyc = 0; gapc = 0; amis = 0; omax = 0; n = 0;
            while (busy_o && n < 200) begin
                if (grant_o != '0) gcyc++; else gapc++;
                if (addr_o != vt[v].addr) amis++;
                if (int'(dut.r_outst) > omax) omax = int'(dut.r_outst);
                tick();
                n++;
            end
            chk($sformatf("v%0d_grant_cycles", v), gcyc, vt[v].gcyc);
            chk($sformatf("v%0d_gap_cycles", v), gapc, 4);
            chk($sformatf("v%0d_addr_unstable", v), amis, 0);
            chk($sformatf("v%0d_outst_max", v), omax, 1);
            check_rx($sformatf("v%0d_rx", v), vt[v].req, rx0, vt[v].d0, vt[v].len);
        end

        // Round robin: every requester holds two 1-byte frames.
        reset_dut();
        glog_n = 0; had_grant = 1'b0; min_idle = 999;
        for (int r = 0; r < NR; r++) begin
            push(r, 8'(8'h80 + 8'(r * 16)), 1, 1'b1);
            push(r, 8'(8'h81 + 8'(r * 16)), 1, 1'b1);
        end
        wait_idle("rr_idle", 300);
        chk("rr_ngrants", glog_n, 8);
        chk("rr_g0", glog[0], 0);
        chk("rr_g1", glog[1], 1);
        chk("rr_g2", glog[2], 2);
        chk("rr_g3", glog[3], 3);
        chk("rr_g4", glog[4], 0);
        chk("rr_min_idle_ge5", {31'd0, min_idle >= 5}, 32'd1);
        chk("rr_leak", leak_cnt, 0);

        // Burst limit: requester 2 offers 20 beats, tlast only on the last one.
        glog_n = 0; trunc_cnt = 0;
        rx0 = rx_cnt[2];
        sr0 = src_rd[2];
        push(2, 8'h60, 20, 1'b1);
        wait_grant("tr_grant2", 4'b0100, 20);
        push(3, 8'h33, 1, 1'b1);
        push(0, 8'h30, 1, 1'b1);
        n = 0;
        while (grant_o != '0 && n < 60) begin tick(); n++; end
        chk("tr_rsp_at_release", rx_cnt[2] - rx0, 16);
        chk("tr_beats_at_release", src_rd[2] - sr0, 16);
        wait_idle("tr_idle", 300);
        chk("tr_pulses", trunc_cnt, 1);
        chk("tr_ngrants", glog_n, 4);
        chk("tr_g0", glog[0], 2);
        chk("tr_g1", glog[1], 3);
        chk("tr_g2", glog[2], 0);
        chk("tr_g3", glog[3], 2);
        check_rx("tr_rx2", 2, rx0, 8'h60, 20);

        // Response backpressure on requester 0 for 10 cycles.
        rsp_tready_i = 4'b1110;
        rx0 = rx_cnt[0];
        push(0, 8'h70, 3, 1'b1);
        viol = 0; gseen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant_o == 4'b0001) begin
                gseen++;
                if (s_tready_o) viol++;
            end
        end
        chk("bp_sready_viol", viol, 0);
        chk("bp_granted_cycles", gseen, 9);
        chk("bp_grant_held", {28'd0, grant_o}, 32'h1);
        chk("bp_outst", {27'd0, dut.r_outst}, 32'd3);
        chk("bp_rspv", {28'd0, rsp_tvalid_o}, 32'h1);
        rsp_tready_i = 4'b1111;
        wait_idle("bp_idle", 100);
        chk("bp_outst_end", {27'd0, dut.r_outst}, 32'd0);
        check_rx("bp_rx0", 0, rx0, 8'h70, 3);

        // Reset in the middle of a 4-beat frame after 2 beats.
        rx0 = rx_cnt[0];
        sr0 = src_rd[0];
        push(0, 8'h90, 4, 1'b1);
        wait_grant("rs_grant0", 4'b0001, 20);
        tick();
        tick();
        chk("rs_beats_before", src_rd[0] - sr0, 2);
        rst_i = 1'b1;
        m_tready_i = 1'b0;
        rsp_tready_i = '0;
        push(1, 8'hB1, 1, 1'b1);
        push(2, 8'hB2, 1, 1'b1);
        push(3, 8'hB3, 1, 1'b1);
        tick();
        rst_i = 1'b0;
        m_tready_i = 1'b1;
        rsp_tready_i = '1;
        #1;
        chk("rs_grant", {28'd0, grant_o}, 32'd0);
        chk("rs_busy", {31'd0, busy_o}, 32'd0);
        chk("rs_treq", {28'd0, req_tready_o}, 32'd0);
        chk("rs_addr", {30'd0, addr_o}, 32'd0);
        tick();
        chk("rs_first_grant", {28'd0, grant_o}, 32'h1);
        chk("rs_no_route", rx_cnt[0] - rx0, 1);
        wait_idle("rs_idle", 300);
        chk("rs_rx_cnt", rx_cnt[0] - rx0, 3);
        chk("rs_rx_a", {24'd0, rx_mem[0][rx0]}, 32'h90);
        chk("rs_rx_b", {24'd0, rx_mem[0][rx0 + 1]}, 32'h92);
        chk("rs_rx_c", {24'd0, rx_mem[0][rx0 + 2]}, 32'h93);
        chk("leak_total", leak_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
